syscall_responder: RTL and testbench

Services syscall requests issued by the pipelined MIPS core: it takes the syscall function code and first parameter from the execute-side syscall signals, and raises `busy` back to the hazard unit to freeze the pipeline while it works. It prints integers or characters as an ASCII byte stream over a valid/ready console port, and latches program exit. It is the responder end of the core's syscall request path.

---
 rtl/syscall_responder_if.sv | 24 ++
 rtl/syscall_responder.sv | 191 +++++++++++++++++++
 tb/tb_syscall_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/syscall_responder_if.sv
// Syscall request path and console byte stream between the MIPS core and its syscall responder.
// The slave modport is the responder side; the master modport is the core/console side.
interface syscall_responder_if;
    logic        req_valid;
    logic [31:0] req_funct;
    logic [31:0] req_param;
    logic        busy;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;
    logic        halted;
    logic [31:0] exit_code;
    logic        bad_funct;

    modport slave (
        input  req_valid, req_funct, req_param, char_ready,
        output busy, char_data, char_valid, halted, exit_code, bad_funct
    );

    modport master (
        output req_valid, req_funct, req_param, char_ready,
        input  busy, char_data, char_valid, halted, exit_code, bad_funct
    );
endinterface

// File: rtl/syscall_responder.sv
// Syscall responder: print int (double-dabble to ASCII), print char, exit/exit2, stalls the core via busy.
// Optional macro SYSCALL_NEWLINE_EN appends 0x0A after every printed integer.
module syscall_responder #(
    parameter int CONV_BITS = 32
) (
    input  logic               clock,
    input  logic               reset,
    syscall_responder_if.slave sys
);
    localparam int NDIG = 10;
    localparam int BW   = 4 * NDIG;
    localparam int CW   = $clog2(CONV_BITS);
    localparam logic [CW-1:0] LAST_ITER = CW'(CONV_BITS - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CONVERT = 3'd1;
    localparam logic [2:0] SIGN    = 3'd2;
    localparam logic [2:0] DIGITS  = 3'd3;
    localparam logic [2:0] CHAR    = 3'd5;
    localparam logic [2:0] HALT    = 3'd6;
`ifdef SYSCALL_NEWLINE_EN
    localparam logic [2:0] NEWLINE = 3'd4;
`endif

    function automatic logic [BW-1:0] addThree(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int i = 0; i < NDIG; i++)
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        return r;
    endfunction

    // Highest nonzero digit; an all-zero value yields digit 0 so "0" is still printed.
    function automatic logic [3:0] topDigit(input logic [BW-1:0] b);
        logic [3:0] m;
        m = 4'd0;
        for (int i = 0; i < NDIG; i++)
            if (b[i*4 +: 4] != 4'd0) m = 4'(i);
        return m;
    endfunction

    function automatic logic [7:0] asciiDigit(input logic [BW-1:0] b, input logic [3:0] idx);
        return 8'h30 + {4'h0, b[idx*4 +: 4]};
    endfunction

    logic [2:0]           state, stateNxt;
    logic [BW-1:0]        bcd, bcdNxt, bcdShift;
    logic [CONV_BITS-1:0] shifter, shiftNxt, shiftShift;
    logic [CW-1:0]        cnt, cntNxt;
    logic [3:0]           digIdx, digNxt;
    logic                 isNeg, negNxt;
    logic                 busyR;
    logic [7:0]           charData, dataNxt;
    logic                 charValid, validNxt;
    logic                 haltedR, haltNxt;
    logic [31:0]          exitCode, exitNxt;
    logic                 badFunct, badNxt;
    logic [31:0]          mag;
    logic                 xfer;

    always_comb begin
        stateNxt = state;
        bcdNxt   = bcd;
        shiftNxt = shifter;
        cntNxt   = cnt;
        digNxt   = digIdx;
        negNxt   = isNeg;
        dataNxt  = charData;
        validNxt = charValid;
        haltNxt  = haltedR;
        exitNxt  = exitCode;
        badNxt   = badFunct;
        xfer     = charValid && sys.char_ready;
        mag      = sys.req_param[31] ? (~sys.req_param + 32'd1) : sys.req_param;
        {bcdShift, shiftShift} = {addThree(bcd), shifter} << 1;

        case (state)
            IDLE: if (sys.req_valid) begin
                if (sys.req_funct == 32'd1) begin
                    negNxt   = sys.req_param[31];
                    shiftNxt = mag[CONV_BITS-1:0];
                    bcdNxt   = '0;
                    cntNxt   = '0;
                    stateNxt = CONVERT;
                end else if (sys.req_funct == 32'd11) begin
                    dataNxt  = sys.req_param[7:0];
                    validNxt = 1'b1;
                    stateNxt = CHAR;
                end else if (sys.req_funct == 32'd10) begin
                    haltNxt  = 1'b1;
                    exitNxt  = 32'd0;
                    stateNxt = HALT;
                end else if (sys.req_funct == 32'd17) begin
                    haltNxt  = 1'b1;
                    exitNxt  = sys.req_param;
                    stateNxt = HALT;
                end else begin
                    badNxt   = 1'b1;
                end
            end
            CONVERT: begin
                bcdNxt   = bcdShift;
                shiftNxt = shiftShift;
                cntNxt   = cnt + 1'b1;
                // Last iteration: first byte is prepared from the final BCD value directly.
                if (cnt == LAST_ITER) begin
                    validNxt = 1'b1;
                    if (isNeg) begin
                        dataNxt  = 8'h2D;
                        stateNxt = SIGN;
                    end else begin
                        digNxt   = topDigit(bcdShift);
                        dataNxt  = asciiDigit(bcdShift, topDigit(bcdShift));
                        stateNxt = DIGITS;
                    end
                end
            end
            SIGN: if (xfer) begin
                digNxt   = topDigit(bcd);
                dataNxt  = asciiDigit(bcd, topDigit(bcd));
                stateNxt = DIGITS;
            end
            DIGITS: if (xfer) begin
                if (digIdx == 4'd0) begin
`ifdef SYSCALL_NEWLINE_EN
                    dataNxt  = 8'h0A;
                    stateNxt = NEWLINE;
`else
                    validNxt = 1'b0;
                    stateNxt = IDLE;
`endif
                end else begin
                    digNxt  = digIdx - 4'd1;
                    dataNxt = asciiDigit(bcd, digIdx - 4'd1);
                end
            end
`ifdef SYSCALL_NEWLINE_EN
            NEWLINE: if (xfer) begin
                validNxt = 1'b0;
                stateNxt = IDLE;
            end
`endif
            CHAR: if (xfer) begin
                validNxt = 1'b0;
                stateNxt = IDLE;
            end
            HALT: ;
            default: begin
                validNxt = 1'b0;
                stateNxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bcd       <= '0;
            shifter   <= '0;
            cnt       <= '0;
            digIdx    <= '0;
            isNeg     <= 1'b0;
            busyR     <= 1'b0;
            charData  <= 8'h00;
            charValid <= 1'b0;
            haltedR   <= 1'b0;
            exitCode  <= 32'd0;
            badFunct  <= 1'b0;
        end else begin
            state     <= stateNxt;
            bcd       <= bcdNxt;
            shifter   <= shiftNxt;
            cnt       <= cntNxt;
            digIdx    <= digNxt;
            isNeg     <= negNxt;
            busyR     <= (stateNxt != IDLE);
            charData  <= dataNxt;
            charValid <= validNxt;
            haltedR   <= haltNxt;
            exitCode  <= exitNxt;
            badFunct  <= badNxt;
        end
    end

    assign sys.busy       = busyR;
    assign sys.char_data  = charData;
    assign sys.char_valid = charValid;
    assign sys.halted     = haltedR;
    assign sys.exit_code  = exitCode;
    assign sys.bad_funct  = badFunct;
endmodule

// File: tb/tb_syscall_responder.sv
// Directed self-checking bench for syscall_responder; each scenario task checks its own results.
module tb_syscall_responder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   nl;

    syscall_responder_if bus ();

    syscall_responder #(.CONV_BITS(32)) dut (
        .clock (clock),
        .reset (reset),
        .sys   (bus)
    );

    always #5 clock = ~clock;

    // Results of the most recent collect() call.
    logic [7:0] got[$];
    int         busyCyc;
    int         firstV;
    int         unstable;
    bit         tmo;

    // Presents one request for exactly one rising edge; returns at the following falling edge.
    task automatic issue(input logic [31:0] funct, input logic [31:0] param);
        bus.req_valid = 1'b1;
        bus.req_funct = funct;
        bus.req_param = param;
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    // Records bytes until the responder is idle again; cycle k is the one after edge N+k.
    task automatic collect(input bit toggle);
        logic [7:0] prevData;
        bit         prevHold;
        got = {};
        busyCyc = 0; firstV = -1; unstable = 0; tmo = 1'b1; prevHold = 1'b0; prevData = 8'h00;
        for (int k = 0; k < 300; k++) begin
            bus.char_ready = toggle ? (k % 2 == 0) : 1'b1;
            if (prevHold && bus.char_data !== prevData) unstable++;
            if (!bus.busy && !bus.char_valid) begin
                tmo = 1'b0;
                break;
            end
            if (bus.busy) busyCyc++;
            if (bus.char_valid && firstV < 0) firstV = k;
            if (bus.char_valid && bus.char_ready) got.push_back(bus.char_data);
            prevHold = bus.char_valid && !bus.char_ready;
            prevData = bus.char_data;
            @(negedge clock);
        end
        bus.char_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
        checks++; if (bus.char_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", bus.char_valid); end
        checks++; if (bus.char_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", bus.char_data); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%0b want=0", bus.halted); end
        checks++; if (bus.exit_code !== 32'd0) begin errors++; $display("FAIL reset_exit got=%h want=0", bus.exit_code); end
        checks++; if (bus.bad_funct !== 1'b0) begin errors++; $display("FAIL reset_bad got=%0b want=0", bus.bad_funct); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_print_char();
        issue(32'd11, 32'h0000_0141);
        collect(1'b0);
        checks++; if (tmo) begin errors++; $display("FAIL char_timeout got=busy_stuck want=idle"); end
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL char_count got=%0d want=1", got.size()); end
        else begin
            checks++; if (got[0] !== 8'h41) begin errors++; $display("FAIL char_byte got=%h want=41", got[0]); end
        end
        checks++; if (firstV !== 0) begin errors++; $display("FAIL char_first_valid got=%0d want=0", firstV); end
        checks++; if (busyCyc !== 1) begin errors++; $display("FAIL char_busy_cycles got=%0d want=1", busyCyc); end
    endtask

    task automatic test_print_int(input logic [31:0] param, input string txt, input bit toggle);
        string exp;
        exp = nl ? {txt, "\n"} : txt;
        issue(32'd1, param);
        collect(toggle);
        checks++; if (tmo) begin errors++; $display("FAIL int_timeout[%s] got=busy_stuck want=idle", txt); end
        checks++; if (got.size() !== exp.len()) begin errors++; $display("FAIL int_count[%s] got=%0d want=%0d", txt, got.size(), exp.len()); end
        else for (int i = 0; i < exp.len(); i++) begin
            checks++;
            if (got[i] !== 8'(exp[i])) begin errors++; $display("FAIL int_byte[%s][%0d] got=%h want=%h", txt, i, got[i], exp[i]); end
        end
        checks++; if (firstV !== 32) begin errors++; $display("FAIL int_first_valid[%s] got=%0d want=32", txt, firstV); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL int_data_stable[%s] got=%0d changes want=0", txt, unstable); end
        if (!toggle) begin
            checks++;
            if (busyCyc !== 32 + exp.len()) begin errors++; $display("FAIL int_busy_cycles[%s] got=%0d want=%0d", txt, busyCyc, 32 + exp.len()); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int busyLow;
        n = 0; busyLow = 0;
        bus.req_valid = 1'b1; bus.req_funct = 32'd11; bus.req_param = 32'h42;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (bus.char_valid && bus.char_ready) n++;
            if (!bus.busy) busyLow++;
        end
        bus.req_valid = 1'b0;
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_transfers got=%0d want=2", n); end
        checks++; if (busyLow !== 2) begin errors++; $display("FAIL b2b_idle_cycles got=%0d want=2", busyLow); end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_exit();
        int leaks;
        issue(32'd17, 32'd7);
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL exit2_halted got=%0b want=1", bus.halted); end
        checks++; if (bus.exit_code !== 32'd7) begin errors++; $display("FAIL exit2_code got=%0d want=7", bus.exit_code); end
        issue(32'd11, 32'h41);
        leaks = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.char_valid !== 1'b0 || bus.busy !== 1'b1 || bus.halted !== 1'b1) leaks++;
            @(negedge clock);
        end
        checks++; if (leaks !== 0) begin errors++; $display("FAIL halt_terminal got=%0d bad cycles want=0", leaks); end
        reset = 1'b1; @(negedge clock); reset = 1'b0; @(negedge clock);
        issue(32'd10, 32'd5);
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL exit_halted got=%0b want=1", bus.halted); end
        checks++; if (bus.exit_code !== 32'd0) begin errors++; $display("FAIL exit_code got=%0d want=0", bus.exit_code); end
        reset = 1'b1; @(negedge clock); reset = 1'b0; @(negedge clock);
    endtask

    task automatic test_bad_funct();
        int busyHigh;
        busyHigh = 0;
        checks++; if (bus.bad_funct !== 1'b0) begin errors++; $display("FAIL bad_before got=%0b want=0", bus.bad_funct); end
        issue(32'd99, 32'h41);
        for (int i = 0; i < 3; i++) begin
            if (bus.busy !== 1'b0 || bus.char_valid !== 1'b0) busyHigh++;
            @(negedge clock);
        end
        checks++; if (bus.bad_funct !== 1'b1) begin errors++; $display("FAIL bad_set got=%0b want=1", bus.bad_funct); end
        checks++; if (busyHigh !== 0) begin errors++; $display("FAIL bad_busy got=%0d active cycles want=0", busyHigh); end
    endtask

    task automatic test_reset_mid_convert();
        issue(32'd1, 32'd98765);
        repeat (10) @(negedge clock);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midconv_busy got=%0b want=1", bus.busy); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0b want=0", bus.busy); end
        checks++; if (bus.char_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%0b want=0", bus.char_valid); end
        checks++; if (bus.char_data !== 8'h00) begin errors++; $display("FAIL midrst_data got=%h want=00", bus.char_data); end
        checks++; if (bus.bad_funct !== 1'b0) begin errors++; $display("FAIL midrst_bad got=%0b want=0", bus.bad_funct); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL midrst_halted got=%0b want=0", bus.halted); end
        reset = 1'b0;
        @(negedge clock);
        issue(32'd11, 32'h5A);
        collect(1'b0);
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL postrst_count got=%0d want=1", got.size()); end
        else begin
            checks++; if (got[0] !== 8'h5A) begin errors++; $display("FAIL postrst_byte got=%h want=5a", got[0]); end
        end
    endtask

    initial begin
`ifdef SYSCALL_NEWLINE_EN
        nl = 1'b1;
`else
        nl = 1'b0;
`endif
        bus.req_valid = 1'b0; bus.req_funct = 32'd0; bus.req_param = 32'd0; bus.char_ready = 1'b1;
        test_reset();
        test_print_char();
        test_print_int(32'd0, "0", 1'b0);
        test_print_int(32'h8000_0000, "-2147483648", 1'b0);
        test_print_int(32'd1234, "1234", 1'b1);
        test_print_int(32'hFFFF_FFF9, "-7", 1'b0);
        test_back_to_back();
        test_exit();
        test_bad_funct();
        test_reset_mid_convert();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
